// File: rtl/mem_access_stage_if.sv
// Bus bundle for the MEM stage: upstream op/stall, data-memory handshake,
// and the result side that feeds the MEM/WB register.
interface mem_access_stage_if;
  // upstream (EX/MEM)
  logic        valid_in;
  logic [3:0]  opcode;
  logic [15:0] aluRESULT;
  logic [19:0] store_data;
  logic        stall;
  // data memory
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [19:0] mem_wdata;
  logic        mem_ready;
  logic [19:0] mem_rdata;
  // downstream (MEM/WB)
  logic        valid_out;
  logic [3:0]  opcode_out;
  logic [15:0] aluRESULT_out;
  logic [19:0] memory_read_data;
  logic        mem_error;

  // stage view
  modport slave (
    input  valid_in, opcode, aluRESULT, store_data, mem_ready, mem_rdata,
    output stall, mem_req, mem_we, mem_addr, mem_wdata,
           valid_out, opcode_out, aluRESULT_out, memory_read_data, mem_error
  );

  // environment view (pipeline + memory)
  modport master (
    output valid_in, opcode, aluRESULT, store_data, mem_ready, mem_rdata,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata,
           valid_out, opcode_out, aluRESULT_out, memory_read_data, mem_error
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: single-cycle pass-through for non-memory ops, a
// req/ready handshake for loads/stores with upstream stall, and a bounded
// wait that aborts with mem_error when memory never answers.
module mem_access_stage #(
  parameter logic [3:0] OP_LOAD  = 4'h2,
  parameter logic [3:0] OP_STORE = 4'h3,
  parameter int         TIMEOUT  = 16
) (
  input  logic              clock,
  input  logic              reset,
  mem_access_stage_if.slave bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;      // doubles as the latched aluRESULT
  logic [19:0] wdata_q, wdata_d;
  logic [3:0]  op_q, op_d;
  logic        vo_q, vo_d;
  logic        err_q, err_d;
  logic [3:0]  opo_q, opo_d;
  logic [15:0] alu_q, alu_d;
  logic [19:0] rd_q, rd_d;
  logic        stall_c;
  logic        is_mem;

  assign is_mem = bus.valid_in && (bus.opcode == OP_LOAD || bus.opcode == OP_STORE);

  // Next-state, result and stall decode; outputs hold unless a result is produced.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    vo_d    = 1'b0;
    err_d   = 1'b0;
    opo_d   = opo_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          stall_c = 1'b1;
          op_d    = bus.opcode;
          addr_d  = bus.aluRESULT;
          wdata_d = bus.store_data;
          we_d    = (bus.opcode == OP_STORE);
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end else if (bus.valid_in) begin
          vo_d  = 1'b1;
          opo_d = bus.opcode;
          alu_d = bus.aluRESULT;
          rd_d  = 20'd0;
        end
      end
      S_WAIT: begin
        // ready wins over the timeout when both land in the same cycle
        if (bus.mem_ready) begin
          req_d   = 1'b0;
          vo_d    = 1'b1;
          opo_d   = op_q;
          alu_d   = addr_q;
          rd_d    = (op_q == OP_LOAD) ? bus.mem_rdata : 20'd0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          vo_d    = 1'b1;
          err_d   = 1'b1;
          opo_d   = op_q;
          alu_d   = addr_q;
          rd_d    = 20'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          stall_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 20'd0;
      op_q    <= 4'd0;
      vo_q    <= 1'b0;
      err_q   <= 1'b0;
      opo_q   <= 4'd0;
      alu_q   <= 16'd0;
      rd_q    <= 20'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      vo_q    <= vo_d;
      err_q   <= err_d;
      opo_q   <= opo_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.stall            = stall_c;
  assign bus.mem_req          = req_q;
  assign bus.mem_we           = we_q;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_wdata        = wdata_q;
  assign bus.valid_out        = vo_q;
  assign bus.opcode_out       = opo_q;
  assign bus.aluRESULT_out    = alu_q;
  assign bus.memory_read_data = rd_q;
  assign bus.mem_error        = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random ops, each checked
// against a transaction-level expectation (latency, stall/req counts, result).
module tb_mem_access_stage;
  localparam logic [3:0] LD = 4'h2;
  localparam logic [3:0] ST = 4'h3;
  localparam int         TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  logic [3:0]  last_op  = '0;
  logic [15:0] last_alu = '0;
  logic [19:0] last_rd  = '0;

  mem_access_stage_if bus ();

  mem_access_stage #(.OP_LOAD(LD), .OP_STORE(ST), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One idle cycle with garbage inputs: no result, outputs hold.
  task automatic idle_cycle();
    @(negedge clock);
    bus.valid_in   = 1'b0;
    bus.opcode     = 4'($urandom);
    bus.aluRESULT  = 16'($urandom);
    bus.store_data = 20'($urandom);
    bus.mem_ready  = 1'($urandom);
    bus.mem_rdata  = 20'($urandom);
    #1 chk("idle_stall", bus.stall, 0);
    @(posedge clock); #1;
    chk("idle_vo", bus.valid_out, 0);
    chk("idle_err", bus.mem_error, 0);
    chk("idle_req", bus.mem_req, 0);
    chk("hold_op", bus.opcode_out, last_op);
    chk("hold_alu", bus.aluRESULT_out, last_alu);
    chk("hold_rd", bus.memory_read_data, last_rd);
  endtask

  // Present one op; memory answers in WAIT cycle k (k > TO means never).
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [19:0] wd,
                        input int k, input logic [19:0] rd);
    bit mem, ok, exp_err, done;
    int lat, n_wait, stall_cnt, req_cnt, j;
    logic [19:0] exp_rd;
    mem     = (op == LD) || (op == ST);
    ok      = mem && (k <= TO);
    exp_err = mem && !ok;
    n_wait  = !mem ? 0 : (ok ? k : TO);
    lat     = n_wait + 1;
    exp_rd  = (op == LD && ok) ? rd : 20'd0;

    @(negedge clock);
    bus.valid_in   = 1'b1;
    bus.opcode     = op;
    bus.aluRESULT  = a;
    bus.store_data = wd;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 20'($urandom);
    #1 chk("acc_stall", bus.stall, 32'(mem));
    stall_cnt = bus.stall ? 1 : 0;
    req_cnt = 0;
    j = 0;
    done = 0;
    @(posedge clock); #1;
    while (j < TO + 5) begin
      if (bus.valid_out) begin
        done = 1;
        break;
      end
      j++;
      if (bus.mem_req) req_cnt++;
      if (j == 1) begin
        chk("addr", bus.mem_addr, a);
        chk("we", bus.mem_we, 32'(op == ST));
        chk("wdata", bus.mem_wdata, wd);
      end
      @(negedge clock);
      // upstream content during WAIT must be ignored
      bus.valid_in   = 1'($urandom);
      bus.opcode     = 4'($urandom);
      bus.aluRESULT  = 16'($urandom);
      bus.store_data = 20'($urandom);
      bus.mem_ready  = (j == k);
      bus.mem_rdata  = (j == k) ? rd : 20'($urandom);
      #1 if (bus.stall) stall_cnt++;
      @(posedge clock); #1;
    end
    chk("done", 32'(done), 1);
    chk("latency", j + 1, lat);
    chk("stall_cyc", stall_cnt, n_wait);
    chk("req_cyc", req_cnt, n_wait);
    chk("err", bus.mem_error, 32'(exp_err));
    chk("rdata", bus.memory_read_data, exp_rd);
    chk("req_drop", bus.mem_req, 0);
    chk("op_out", bus.opcode_out, op);
    chk("alu_out", bus.aluRESULT_out, a);
    last_op  = op;
    last_alu = a;
    last_rd  = exp_rd;
  endtask

  initial begin
    bus.valid_in = 0; bus.opcode = 0; bus.aluRESULT = 0; bus.store_data = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    #2;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_vo", bus.valid_out, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_rd", bus.memory_read_data, 0);
    @(negedge clock); reset = 1'b1;
    idle_cycle();

    // directed cases
    run_op(4'h1, 16'h1234, 20'h0, 1, 20'h0);
    idle_cycle();
    run_op(LD, 16'h0040, 20'h0, 3, 20'hABCDE);
    idle_cycle();
    run_op(ST, 16'h0010, 20'h12345, 1, 20'h55555);
    run_op(4'h7, 16'hBEEF, 20'h0, 1, 20'h0);   // back-to-back, store not repeated
    idle_cycle();
    run_op(LD, 16'h0ACE, 20'h0, TO + 10, 20'h11111);  // timeout
    idle_cycle();
    run_op(LD, 16'h0BCD, 20'h0, TO, 20'h7F00D);       // ready on the last cycle
    idle_cycle();

    // reset in the middle of a load
    @(negedge clock);
    bus.valid_in = 1; bus.opcode = LD; bus.aluRESULT = 16'hFFFF; bus.store_data = 20'hFFFFF;
    bus.mem_ready = 0;
    @(negedge clock); bus.valid_in = 0;
    @(negedge clock);
    #1 chk("mid_req", bus.mem_req, 1);
    #1 reset = 1'b0;
    #1;
    chk("mr_req", bus.mem_req, 0);
    chk("mr_we", bus.mem_we, 0);
    chk("mr_addr", bus.mem_addr, 0);
    chk("mr_wdata", bus.mem_wdata, 0);
    chk("mr_vo", bus.valid_out, 0);
    chk("mr_op", bus.opcode_out, 0);
    chk("mr_alu", bus.aluRESULT_out, 0);
    chk("mr_rd", bus.memory_read_data, 0);
    chk("mr_err", bus.mem_error, 0);
    chk("mr_stall", bus.stall, 0);
    @(negedge clock); reset = 1'b1;
    last_op = 0; last_alu = 0; last_rd = 0;
    for (int i = 0; i < TO + 4; i++) idle_cycle();

    // random ops
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      int sel;
      sel = $urandom_range(0, 2);
      op  = (sel == 0) ? LD : (sel == 1) ? ST : 4'($urandom);
      run_op(op, 16'($urandom), 20'($urandom), $urandom_range(1, TO + 2), 20'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the pipelined processor. It sits between the EX/MEM pipeline register and the MEM/WB register, and feeds the MEM/WB register's `opcode`, `aluRESULT` and `memory_read_data` inputs. Non-memory operations pass through in one cycle. Loads and stores run a request/ready handshake with data memory, stall upstream until the access completes, and abort with an error if memory does not answer within a bounded time.

## Interface
- `OP_LOAD`, default 4'h2: opcode treated as a load.
- `OP_STORE`, default 4'h3: opcode treated as a store.
- `TIMEOUT`, default 16: maximum WAIT cycles without `mem_ready` before abort (range 1..255).
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low.
- `valid_in`  in  1: an operation from EX/MEM is present.
- `opcode`  in  4: operation code.
- `aluRESULT`  in  16: ALU result; used as the address for loads and stores.
- `store_data`  in  20: write data for stores.
- `mem_req`  out  1: memory request, registered.
- `mem_we`  out  1: 1 = write, 0 = read; meaningful only while `mem_req` is high.
- `mem_addr`  out  16: memory address.
- `mem_wdata`  out  20: memory write data.
- `mem_ready`  in  1: memory completes the current request.
- `mem_rdata`  in  20: read data; valid in the cycle `mem_ready` is high.
- `stall`  out  1: combinational; upstream must hold its contents while this is high.
- `valid_out`  out  1: one-cycle pulse when a result is presented to MEM/WB.
- `opcode_out`  out  4: opcode of the completed operation.
- `aluRESULT_out`  out  16: ALU result of the completed operation.
- `memory_read_data`  out  20: load data; 0 for non-loads and for aborted loads.
- `mem_error`  out  1: pulses together with `valid_out` when the access timed out.

## Operation
- **State machine:** two states, IDLE and WAIT, plus an 8-bit wait counter `cnt`.
- **Memory op:** `is_mem` = `valid_in` and (`opcode` == `OP_LOAD` or `opcode` == `OP_STORE`).
- **IDLE, `valid_in` with a non-memory opcode:**
  - At the next edge: `valid_out`=1, `opcode_out`/`aluRESULT_out` = inputs, `memory_read_data`=0.
  - State stays IDLE.
- **IDLE, `is_mem`:**
  - At the next edge, latch `opcode` and `aluRESULT`.
  - Drive `mem_req`=1, `mem_addr`=`aluRESULT`, `mem_wdata`=`store_data`, `mem_we`=(`opcode`==`OP_STORE`).
  - Set `cnt`=0 and go to WAIT.
- **WAIT, `mem_ready`=1:**
  - At the next edge: `mem_req`=0, `valid_out`=1, `mem_error`=0, latched opcode and address go to the outputs.
  - `memory_read_data` = `mem_rdata` for a load, 0 for a store.
  - Go to IDLE.
- **WAIT, `mem_ready`=0 and `cnt` == `TIMEOUT`-1:**
  - Abort at the next edge: `mem_req`=0, `valid_out`=1, `mem_error`=1, `memory_read_data`=0.
  - Go to IDLE.
- **WAIT, otherwise:** `cnt` increments by 1 and the state stays WAIT.
- **`stall` equation:** (IDLE and `is_mem`) or (WAIT and not `mem_ready` and not (`cnt` == `TIMEOUT`-1)).
  - `stall` is low in the completion cycle, so upstream advances on the same edge the stage returns to IDLE.
  - The same operation is therefore never accepted twice.
- **Inputs ignored:** `valid_in`, `opcode`, `aluRESULT` and `store_data` are ignored in WAIT. `mem_ready` is ignored in IDLE.
- **Simultaneous events:** `mem_ready` in the cycle where `cnt` == `TIMEOUT`-1 counts as success; no error is flagged.
- **Output hold:** while `valid_out`=0, `opcode_out`, `aluRESULT_out` and `memory_read_data` hold their last values. `mem_error` is 0.
- **Reset (asserted low, asynchronous, including mid-access):**
  - State goes to IDLE and `cnt`=0.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `valid_out`, `opcode_out`, `aluRESULT_out`, `memory_read_data` and `mem_error` all go to 0 immediately.
  - `stall` follows its equation with state IDLE.
  - An in-flight access is dropped; no `valid_out` is produced for it.

## Timing
- **Non-memory op:** 1-cycle latency; `stall` never asserted.
- **Load/store with `mem_ready` in WAIT cycle k (k = 1 is the first WAIT cycle):**
  - `valid_out` appears k+1 edges after the accept cycle.
  - `stall` is high for k cycles: the accept cycle plus k-1 WAIT cycles.
- **Minimum memory-op latency:** 2 cycles.
- **Timeout:** `mem_req` is high for exactly `TIMEOUT` cycles, then `valid_out` and `mem_error` pulse together.
- **Back-to-back ops:** the next op can be accepted in the first IDLE cycle after completion, so `mem_req` is low for at least 1 cycle between accesses.

## Test plan
- **Reset mid-access:** assert `reset`=0 while in WAIT with `mem_req`=1 -> all outputs 0 immediately; after release, no `valid_out` is produced for the dropped access.
- **Non-memory pass-through:** `valid_in`=1, `opcode`=4'h1, `aluRESULT`=16'h1234 -> next cycle `valid_out`=1, `aluRESULT_out`=16'h1234, `memory_read_data`=0, `stall`=0 throughout.
- **Load:** `OP_LOAD`, `aluRESULT`=16'h0040, `mem_ready` in WAIT cycle 3 with `mem_rdata`=20'hABCDE ->
  - `mem_addr`=16'h0040, `mem_we`=0.
  - `stall` high 3 cycles.
  - `valid_out` 4 cycles after accept with `memory_read_data`=20'hABCDE.
- **Store, then back-to-back op:** `OP_STORE`, address 16'h0010, `store_data`=20'h12345, immediate `mem_ready` ->
  - `mem_we`=1, `mem_wdata`=20'h12345.
  - `valid_out` at 2 cycles with `memory_read_data`=0.
  - A following non-memory op is accepted without duplicating the store.
- **Timeout:** `OP_LOAD` with `mem_ready` never asserted and `TIMEOUT`=16 -> `mem_req` high 16 cycles, then `valid_out`=1, `mem_error`=1, `memory_read_data`=0.
- **Boundary:** `mem_ready` arrives exactly in WAIT cycle 16 with `TIMEOUT`=16 -> success, `mem_error`=0, data captured.
